// File: rtl/jpeg_idct_col_pack_if.sv
// Column packer stream bundle: transposed beats in, packed columns out.
// The upstream side (transpose stage) is master, the packer is slave.
interface jpeg_idct_col_pack_if;
    logic         inport_valid_i;
    logic [31:0]  inport_data0_i;
    logic [31:0]  inport_data1_i;
    logic [31:0]  inport_data2_i;
    logic [31:0]  inport_data3_i;
    logic [2:0]   inport_idx_i;
    logic         inport_ready_o;
    logic         outport_valid_o;
    logic [127:0] outport_data_o;
    logic         outport_last_o;
    logic         outport_ready_i;

    modport master (
        output inport_valid_i,
        output inport_data0_i,
        output inport_data1_i,
        output inport_data2_i,
        output inport_data3_i,
        output inport_idx_i,
        output outport_ready_i,
        input  inport_ready_o,
        input  outport_valid_o,
        input  outport_data_o,
        input  outport_last_o
    );

    modport slave (
        input  inport_valid_i,
        input  inport_data0_i,
        input  inport_data1_i,
        input  inport_data2_i,
        input  inport_data3_i,
        input  inport_idx_i,
        input  outport_ready_i,
        output inport_ready_o,
        output outport_valid_o,
        output outport_data_o,
        output outport_last_o
    );
endinterface

// File: rtl/jpeg_idct_col_pack.sv
// Pairs even/odd transposed beats into saturated 8x16 columns and buffers
// them in a FIFO deep enough to absorb a whole block without backpressure.
module jpeg_idct_col_pack #(
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  img_start_i,
    jpeg_idct_col_pack_if.slave   bus,
    output logic                  overflow_o,
    output logic                  seq_err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] RDY_CNT  = CW'(FIFO_DEPTH - 32);

    function automatic logic [15:0] sat16(input logic [31:0] v);
        logic signed [31:0] s;
        s = $signed(v);
        if (s > 32'sd32767) begin
            return 16'h7FFF;
        end else if (s < -32'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

    logic            flush;
    logic            beat_v;
    logic            is_odd;
    logic [63:0]     cur_sat;
    logic            pair_hit;
    logic            seq_hit;

    logic            held_q;
    logic            held_d;
    logic [2:0]      held_idx_q;
    logic [2:0]      held_idx_d;
    logic [63:0]     half_q;
    logic [63:0]     half_d;

    logic [4:0]      col_cnt_q;
    logic [4:0]      col_cnt_d;

    logic [128:0]    mem_q [FIFO_DEPTH];
    logic [128:0]    push_entry;
    logic [128:0]    head;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   rd_ptr_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            full;
    logic            not_empty;
    logic            pop;
    logic            push_ok;
    logic            drop;

    logic            ovf_q;
    logic            ovf_d;
    logic            seq_q;
    logic            seq_d;

    // A beat coinciding with a flush is discarded outright.
    assign flush  = rst_i | img_start_i;
    assign beat_v = bus.inport_valid_i & ~flush;
    assign is_odd = bus.inport_idx_i[0];

    assign cur_sat = {
        sat16(bus.inport_data3_i),
        sat16(bus.inport_data2_i),
        sat16(bus.inport_data1_i),
        sat16(bus.inport_data0_i)
    };

    assign pair_hit = beat_v & is_odd & held_q
                    & (bus.inport_idx_i == {held_idx_q[2:1], 1'b1});
    assign seq_hit  = beat_v & ((~is_odd & held_q) | (is_odd & ~pair_hit));

    always_comb begin
        held_d     = held_q;
        held_idx_d = held_idx_q;
        half_d     = half_q;
        if (beat_v) begin
            if (!is_odd) begin
                held_d     = 1'b1;
                held_idx_d = bus.inport_idx_i;
                half_d     = cur_sat;
            end else begin
                held_d     = 1'b0;
            end
        end
    end

    // Counter advances even on dropped pushes to keep block alignment.
    assign col_cnt_d  = pair_hit ? col_cnt_q + 5'd1 : col_cnt_q;
    assign push_entry = {col_cnt_q == 5'd31, cur_sat, half_q};

    assign not_empty = count_q != '0;
    assign full      = count_q == FULL_CNT;
    assign pop       = not_empty & bus.outport_ready_i;
    assign push_ok   = pair_hit & (~full | pop);
    assign drop      = pair_hit & ~push_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    assign ovf_d = ovf_q | drop;
    assign seq_d = seq_q | seq_hit;

    always_ff @(posedge clk_i) begin
        if (flush) begin
            held_q    <= 1'b0;
            col_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            seq_q     <= 1'b0;
        end else begin
            held_q    <= held_d;
            col_cnt_q <= col_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            seq_q     <= seq_d;
        end
    end

    always_ff @(posedge clk_i) begin
        held_idx_q <= held_idx_d;
        half_q     <= half_d;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Head is read from storage and gated so an empty FIFO shows zeros.
    assign head                = mem_q[rd_ptr_q];
    assign bus.outport_valid_o = not_empty;
    assign bus.outport_data_o  = not_empty ? head[127:0] : '0;
    assign bus.outport_last_o  = not_empty & head[128];
    assign bus.inport_ready_o  = count_q <= RDY_CNT;

    assign overflow_o = ovf_q;
    assign seq_err_o  = seq_q;
endmodule

// File: tb/tb_jpeg_idct_col_pack.sv
// Self-checking bench for jpeg_idct_col_pack: vector table, scoreboard
// queue fed by the driver and drained by an output monitor.
module tb_jpeg_idct_col_pack;
    logic clk = 1'b0;
    logic rst;
    logic img_start;
    logic ovf;
    logic serr;

    jpeg_idct_col_pack_if bus();

    always #5 clk = ~clk;

    jpeg_idct_col_pack #(.FIFO_DEPTH(64)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .img_start_i (img_start),
        .bus         (bus),
        .overflow_o  (ovf),
        .seq_err_o   (serr)
    );

    int total = 0;
    int bad   = 0;

    logic [128:0] sbq[$];
    bit           m_held;
    logic [2:0]   m_hidx;
    logic [63:0]  m_half;
    logic [4:0]   m_cnt;
    bit           m_seq;
    bit           m_ovf;

    typedef struct packed {
        logic [2:0]   idx;
        logic [127:0] ev;
        logic [127:0] od;
        logic [127:0] exp;
    } vec_t;
    vec_t vt[3];

    function automatic logic [15:0] sat16(input logic [31:0] v);
        int s;
        s = int'($signed(v));
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    task automatic chk(input string name, input logic [128:0] act,
                       input logic [128:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Output monitor: pops scoreboard on handshake, checks hold stability.
    bit           pv;
    bit           pr;
    logic [128:0] pd;
    always @(negedge clk) begin
        if (pv && !pr && bus.outport_valid_o === 1'b1)
            chk("hold_stable", {bus.outport_last_o, bus.outport_data_o}, pd);
        if (bus.outport_valid_o === 1'b1 && bus.outport_ready_i === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_col: got %0h want none",
                         bus.outport_data_o);
            end else begin
                chk("col", {bus.outport_last_o, bus.outport_data_o},
                    sbq.pop_front());
            end
        end
        pv <= bus.outport_valid_o === 1'b1;
        pr <= bus.outport_ready_i === 1'b1;
        pd <= {bus.outport_last_o, bus.outport_data_o};
    end

    task automatic model_flush();
        sbq.delete();
        m_held = 0;
        m_cnt  = '0;
        m_seq  = 0;
        m_ovf  = 0;
    endtask

    task automatic beat(input logic [2:0] idx, input logic [31:0] l0,
                        input logic [31:0] l1, input logic [31:0] l2,
                        input logic [31:0] l3, input bit start = 0);
        logic [63:0] s;
        s = {sat16(l3), sat16(l2), sat16(l1), sat16(l0)};
        bus.inport_valid_i = 1'b1;
        bus.inport_idx_i   = idx;
        bus.inport_data0_i = l0;
        bus.inport_data1_i = l1;
        bus.inport_data2_i = l2;
        bus.inport_data3_i = l3;
        img_start          = start;
        if (start) begin
            model_flush();
        end else if (!idx[0]) begin
            if (m_held) m_seq = 1;
            m_held = 1;
            m_hidx = idx;
            m_half = s;
        end else if (m_held && idx == 3'(m_hidx + 3'd1)) begin
            if (sbq.size() < 64 || bus.outport_ready_i)
                sbq.push_back({m_cnt == 5'd31, s, m_half});
            else
                m_ovf = 1;
            m_cnt  = m_cnt + 5'd1;
            m_held = 0;
        end else begin
            m_held = 0;
            m_seq  = 1;
        end
        @(posedge clk);
        #1;
        bus.inport_valid_i = 1'b0;
        img_start          = 1'b0;
    endtask

    task automatic restart();
        img_start = 1'b1;
        model_flush();
        @(posedge clk);
        #1;
        img_start = 1'b0;
    endtask

    task automatic ramp(input int from, input int to, input bit lat);
        for (int b = from; b < to; b++) begin
            beat(3'(b % 8), 32'(b), 32'(b), 32'(b), 32'(b));
            if (lat && (b % 2) == 1) begin
                chk("ramp_lat", bus.outport_valid_o, 1);
                chk("ramp_last", bus.outport_last_o, (b % 64) == 63);
            end
        end
    endtask

    task automatic drain(input string name);
        bus.outport_ready_i = 1'b1;
        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk({name, "_sb_empty"}, sbq.size() == 0, 1);
        chk({name, "_valid0"}, bus.outport_valid_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{3'd0,
            {32'h0000_7FFF_0 >> 4, 32'h0000_7FFF, 32'hFFFE_FFFF, 32'h0001_0000},
            {32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
            128'h7FFF_FFFF_0001_0000_07FF_7FFF_8000_7FFF};
        vt[0].ev = {32'hFFFF_8000, 32'h0000_7FFF, 32'hFFFE_FFFF, 32'h0001_0000};
        vt[0].exp = {16'h7FFF, 16'hFFFF, 16'h0001, 16'h0000,
                     16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
        vt[1] = '{3'd2,
            {32'hFFFF_FEDC, 32'h0000_0123, 32'hFFFF_7FFF, 32'h0000_8000},
            {32'hFFFF_8001, 32'h0000_1000, 32'h8000_0000, 32'h7FFF_FFFF},
            {16'h8001, 16'h1000, 16'h8000, 16'h7FFF,
             16'hFEDC, 16'h0123, 16'h8000, 16'h7FFF}};
        vt[2] = '{3'd6,
            {32'h0, 32'h0, 32'h0, 32'h5},
            {32'hFFFF_FFFE, 32'h0, 32'h0, 32'h0},
            {16'hFFFE, 16'h0, 16'h0, 16'h0,
             16'h0, 16'h0, 16'h0, 16'h5}};

        bus.inport_valid_i  = 1'b0;
        bus.inport_idx_i    = '0;
        bus.inport_data0_i  = '0;
        bus.inport_data1_i  = '0;
        bus.inport_data2_i  = '0;
        bus.inport_data3_i  = '0;
        bus.outport_ready_i = 1'b1;
        img_start           = 1'b0;
        rst                 = 1'b1;
        model_flush();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_valid", bus.outport_valid_o, 0);
        chk("rst_data", bus.outport_data_o, 0);
        chk("rst_last", bus.outport_last_o, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_seq", serr, 0);
        chk("rst_ready", bus.inport_ready_o, 1);

        foreach (vt[i]) begin
            beat(vt[i].idx, vt[i].ev[31:0], vt[i].ev[63:32],
                 vt[i].ev[95:64], vt[i].ev[127:96]);
            chk("vec_pre_valid", bus.outport_valid_o, 0);
            beat(3'(vt[i].idx + 3'd1), vt[i].od[31:0], vt[i].od[63:32],
                 vt[i].od[95:64], vt[i].od[127:96]);
            chk("vec_valid", bus.outport_valid_o, 1);
            chk("vec_data", bus.outport_data_o, vt[i].exp);
            @(posedge clk);
            #1;
        end
        chk("vec_seq", serr, 0);

        restart();
        ramp(0, 64, 1);
        drain("ramp");
        chk("ramp_ovf", ovf, 0);
        chk("ramp_seq", serr, 0);

        restart();
        bus.outport_ready_i = 1'b0;
        ramp(0, 64, 0);
        chk("bp_ready_32", bus.inport_ready_o, 1);
        ramp(64, 66, 0);
        chk("bp_ready_33", bus.inport_ready_o, 0);
        ramp(66, 128, 0);
        chk("bp_ovf_full", ovf, 0);
        chk("bp_sb_64", sbq.size(), 64);
        ramp(128, 192, 0);
        chk("bp_ovf", ovf, 1);
        chk("bp_ovf_model", ovf, m_ovf);
        drain("bp");

        restart();
        bus.outport_ready_i = 1'b0;
        ramp(0, 128, 0);
        beat(3'd0, 32'd200, 32'd201, 32'd202, 32'd203);
        bus.outport_ready_i = 1'b1;
        beat(3'd1, 32'd210, 32'd211, 32'd212, 32'd213);
        bus.outport_ready_i = 1'b0;
        chk("pp_ovf", ovf, 0);
        chk("pp_ready", bus.inport_ready_o, 0);
        beat(3'd2, 32'd220, 32'd221, 32'd222, 32'd223);
        beat(3'd3, 32'd230, 32'd231, 32'd232, 32'd233);
        chk("pp_ovf_after", ovf, 1);
        chk("pp_ovf_model", ovf, m_ovf);
        drain("pp");

        restart();
        beat(3'd1, 32'd1, 32'd2, 32'd3, 32'd4);
        chk("seq_lone_odd", serr, 1);
        chk("seq_lone_nopush", bus.outport_valid_o, 0);
        restart();
        chk("seq_cleared", serr, 0);
        beat(3'd2, 32'd1, 32'd1, 32'd1, 32'd1);
        beat(3'd5, 32'd2, 32'd2, 32'd2, 32'd2);
        chk("seq_mismatch", serr, 1);
        chk("seq_mismatch_nopush", bus.outport_valid_o, 0);
        restart();
        beat(3'd2, 32'd1, 32'd1, 32'd1, 32'd1);
        beat(3'd4, 32'd10, 32'd11, 32'd12, 32'd13);
        beat(3'd5, 32'd20, 32'd21, 32'd22, 32'd23);
        chk("seq_replace", serr, 1);
        chk("seq_replace_valid", bus.outport_valid_o, 1);
        chk("seq_replace_data", bus.outport_data_o,
            128'h0017_0016_0015_0014_000D_000C_000B_000A);
        drain("seq");

        restart();
        bus.outport_ready_i = 1'b0;
        beat(3'd3, 32'd9, 32'd9, 32'd9, 32'd9);
        ramp(0, 14, 0);
        beat(3'd6, 32'd14, 32'd14, 32'd14, 32'd14);
        chk("mid_seq_pre", serr, 1);
        chk("mid_valid_pre", bus.outport_valid_o, 1);
        beat(3'd7, 32'd15, 32'd15, 32'd15, 32'd15, 1);
        chk("mid_valid", bus.outport_valid_o, 0);
        chk("mid_ovf", ovf, 0);
        chk("mid_seq", serr, 0);
        chk("mid_ready", bus.inport_ready_o, 1);
        bus.outport_ready_i = 1'b1;
        ramp(0, 64, 1);
        drain("mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
